dino_game_fsm: RTL and testbench
================================

// Module: dino_game_fsm
// PURPOSE
//   Top-level game sequencer for the dino runner. Owns the 2-bit game_state bus consumed by the game clock
//   divider, renderer and obstacle logic. Advances INIT->START->END->RESET->INIT from player button and
//   collision inputs, and keeps the 4-digit BCD score clocked by rising edges of the game tick.
// PARAMETERS
//   SCORE_DIV          8     game-tick rising edges per score increment (>=1)
//   RESET_HOLD_CYCLES  1000  clk cycles spent in RESET before returning to INIT (>=1)
// PORTS
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   btn_start   in   1   debounced player button, level, synchronous to clk
//   collision   in   1   level from collision detector, synchronous to clk
//   game_tick   in   1   divided game clock (slow, asynchronous to clk in phase)
//   game_state  out  2   0 INIT, 1 START, 2 END, 3 RESET
//   score       out  16  4-digit BCD score, digit 3 in [15:12]
//   high_score  out  16  BCD best score (HIGH_SCORE_EN only, else 16'h0000)
//   new_record  out  1   high while in END after a game that beat high_score
// BEHAVIOUR
//   - Reset: game_state=INIT, score=0, high_score=0, new_record=0, tick counter=0, hold counter=0.
//     Button history flop resets to 1: a button held through reset must be released and re-pressed.
//   - btn_rise = btn_start & ~btn_q (btn_q = btn_start delayed 1 clk). btn_q updates in every state.
//   - game_tick: 2-flop synchroniser then rising-edge detect -> 1-clk tick_p. Score moves no earlier than
//     3 clk edges after game_tick rises.
//   - All outputs registered; a transition takes effect on the clk edge that samples its condition.
//   - INIT: btn_rise -> START; score<=0, tick counter<=0 on that edge. collision ignored.
//   - START: on tick_p, tick counter increments. At SCORE_DIV-1 it wraps to 0 and score increments in BCD
//     (digit 9 -> 0 with carry). Score saturates at 16'h9999 and never wraps.
//     collision=1 -> END on that edge. Collision beats a simultaneous tick_p: no tick count, no score change.
//     btn_start ignored in START apart from history tracking.
//   - END: score frozen. btn_rise -> RESET. collision and tick_p ignored.
//   - RESET: score<=0 and hold counter<=0 on entry. Hold counter counts clk cycles. After
//     RESET_HOLD_CYCLES cycles in RESET -> INIT. btn_rise ignored.
//     Button held across RESET->INIT does not start a game.
//   - Hold counter width $clog2(RESET_HOLD_CYCLES+1). Tick counter width $clog2(SCORE_DIV+1).
//   - rst mid-operation aborts immediately to the reset values above, in any state.
// CONFIGURATION
//   HIGH_SCORE_EN defined:
//     - On the START->END edge: if score > high_score (BCD compare == binary compare), then high_score<=score
//       and new_record<=1. Otherwise new_record<=0.
//     - new_record clears on the END->RESET edge.
//     - high_score survives RESET/INIT. Only rst clears it.
//   HIGH_SCORE_EN undefined: high_score=16'h0000 and new_record=0 constantly; no compare logic built.
// TESTING
//   1. btn_start=1 across rst release, 50 clks -> game_state stays 0. Drop btn 1 clk, raise -> state 1, score 0000.
//   2. SCORE_DIV=8, START, 24 game_tick rises -> score 0003. 80 rises -> 0010 (BCD carry 0009->0010).
//   3. SCORE_DIV=1, 10005 tick rises -> score saturates at 9999 and holds.
//   4. collision asserted on the cycle tick_p would increment -> state 2, score unchanged. btn_rise -> state 3,
//      score 0000. After exactly 1000 clks -> state 0.
//   5. HIGH_SCORE_EN: game A ends at 0012 -> high_score 0012, new_record 1. Game B ends at 0005 -> high_score
//      0012, new_record 0. Without macro: high_score 0000 and new_record 0 throughout.
//   6. rst pulsed mid-START with score 0042 -> state 0, score 0000, high_score 0000 on the same edge (async).

Source files
------------

// File: rtl/dino_game_fsm_if.sv
// rtl/dino_game_fsm_if.sv - player/collision/tick inputs and game state/score outputs of the dino sequencer.
interface dino_game_fsm_if;
  logic        btn_start;
  logic        collision;
  logic        game_tick;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        new_record;

  modport master (
    output btn_start, collision, game_tick,
    input  game_state, score, high_score, new_record
  );

  modport slave (
    input  btn_start, collision, game_tick,
    output game_state, score, high_score, new_record
  );
endinterface

// File: rtl/dino_game_fsm.sv
// rtl/dino_game_fsm.sv - dino runner game sequencer with BCD score; optional high score via HIGH_SCORE_EN.
module dino_game_fsm #(
  parameter int SCORE_DIV         = 8,
  parameter int RESET_HOLD_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  dino_game_fsm_if.slave  bus
);

  localparam int TW = $clog2(SCORE_DIV + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_START = 2'd1,
    S_END   = 2'd2,
    S_RESET = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_score, w_score_nxt;
  logic [TW-1:0]   r_tick_cnt, w_tick_cnt_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic            r_btn_q;
  logic [1:0]      r_tick_sync;
  logic            r_tick_q;
  logic            w_btn_rise;
  logic            w_tick_p;

  // Saturating 4-digit BCD increment.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (r[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign w_btn_rise = bus.btn_start & ~r_btn_q;
  assign w_tick_p   = r_tick_sync[1] & ~r_tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_score     <= 16'h0000;
      r_tick_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_btn_q     <= 1'b1;
      r_tick_sync <= 2'b00;
      r_tick_q    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_btn_q     <= bus.btn_start;
      r_tick_sync <= {r_tick_sync[0], bus.game_tick};
      r_tick_q    <= r_tick_sync[1];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_score_nxt    = r_score;
    w_tick_cnt_nxt = r_tick_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      S_INIT: begin
        if (w_btn_rise) begin
          w_state_nxt    = S_START;
          w_score_nxt    = 16'h0000;
          w_tick_cnt_nxt = '0;
        end
      end
      S_START: begin
        // Collision wins over a tick landing on the same cycle.
        if (bus.collision) begin
          w_state_nxt = S_END;
        end else if (w_tick_p) begin
          if (r_tick_cnt == TW'(SCORE_DIV - 1)) begin
            w_tick_cnt_nxt = '0;
            w_score_nxt    = bcd_inc(r_score);
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      S_END: begin
        if (w_btn_rise) begin
          w_state_nxt    = S_RESET;
          w_score_nxt    = 16'h0000;
          w_hold_cnt_nxt = '0;
        end
      end
      default: begin
        if (r_hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
          w_state_nxt = S_INIT;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HW'(1);
        end
      end
    endcase
  end

  assign bus.game_state = r_state;
  assign bus.score      = r_score;

`ifdef HIGH_SCORE_EN
  logic [15:0] r_high_score, w_high_score_nxt;
  logic        r_new_record, w_new_record_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_score <= 16'h0000;
      r_new_record <= 1'b0;
    end else begin
      r_high_score <= w_high_score_nxt;
      r_new_record <= w_new_record_nxt;
    end
  end

  // Packed BCD orders the same as binary, so a plain compare suffices.
  always_comb begin
    w_high_score_nxt = r_high_score;
    w_new_record_nxt = r_new_record;
    if (r_state == S_START && bus.collision) begin
      if (r_score > r_high_score) begin
        w_high_score_nxt = r_score;
        w_new_record_nxt = 1'b1;
      end else begin
        w_new_record_nxt = 1'b0;
      end
    end else if (r_state == S_END && w_btn_rise) begin
      w_new_record_nxt = 1'b0;
    end
  end

  assign bus.high_score = r_high_score;
  assign bus.new_record = r_new_record;
`else
  assign bus.high_score = 16'h0000;
  assign bus.new_record = 1'b0;
`endif

endmodule

// File: tb/tb_dino_game_fsm.sv
// tb/tb_dino_game_fsm.sv - directed bench for dino_game_fsm (SCORE_DIV=8 and SCORE_DIV=1 instances).
module tb_dino_game_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b1;
  logic collision = 1'b0;
  logic game_tick = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dino_game_fsm_if if_a ();
  dino_game_fsm_if if_b ();

  assign if_a.btn_start = btn_start;
  assign if_a.collision = collision;
  assign if_a.game_tick = game_tick;
  assign if_b.btn_start = btn_start;
  assign if_b.collision = collision;
  assign if_b.game_tick = game_tick;

  dino_game_fsm #(.SCORE_DIV(8), .RESET_HOLD_CYCLES(1000)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  dino_game_fsm #(.SCORE_DIV(1), .RESET_HOLD_CYCLES(1000)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick_rise();
    @(negedge clk) game_tick = 1'b1;
    @(negedge clk);
    @(negedge clk) game_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick_rise();
  endtask

  task automatic press();
    @(negedge clk) btn_start = 1'b0;
    @(negedge clk) btn_start = 1'b1;
    @(negedge clk);
  endtask

  task automatic collide();
    @(negedge clk) collision = 1'b1;
    @(negedge clk) collision = 1'b0;
  endtask

  // Leave END via a held button, then count the exact RESET hold time.
  task automatic reset_cycle(input string tag);
    press();
    check({tag, "_rst_state"}, if_a.game_state, 2'd3);
    check({tag, "_rst_score"}, if_a.score, 16'h0000);
    repeat (999) @(negedge clk);
    check({tag, "_hold999"}, if_a.game_state, 2'd3);
    @(negedge clk);
    check({tag, "_hold1000"}, if_a.game_state, 2'd0);
    repeat (20) @(negedge clk);
    check({tag, "_held_btn"}, if_a.game_state, 2'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", if_a.game_state, 2'd0);
    check("rst_score", if_a.score, 16'h0000);
    check("rst_high", if_a.high_score, 16'h0000);
    check("rst_nr", if_a.new_record, 1'b0);
    repeat (50) @(negedge clk);
    check("held_btn_init", if_a.game_state, 2'd0);

    // Game 1: BCD counting, then collision on the scoring tick.
    press();
    check("g1_start", if_a.game_state, 2'd1);
    check("g1_score0", if_a.score, 16'h0000);
    tick_n(24);
    check("g1_score3", if_a.score, 16'h0003);
    tick_n(56);
    check("g1_score10", if_a.score, 16'h0010);
    tick_n(23);
    check("g1_score12", if_a.score, 16'h0012);
    @(negedge clk) game_tick = 1'b1;
    @(negedge clk);
    @(negedge clk) collision = 1'b1;
    @(negedge clk) begin collision = 1'b0; game_tick = 1'b0; end
    @(negedge clk);
    check("g1_end", if_a.game_state, 2'd2);
    check("g1_frozen", if_a.score, 16'h0012);
    check("g1_b_score", if_b.score, 16'h0103);
`ifdef HIGH_SCORE_EN
    check("g1_high", if_a.high_score, 16'h0012);
    check("g1_nr", if_a.new_record, 1'b1);
`else
    check("g1_high", if_a.high_score, 16'h0000);
    check("g1_nr", if_a.new_record, 1'b0);
`endif
    tick_n(3);
    check("g1_end_ticks", if_a.score, 16'h0012);
    reset_cycle("g1");
    check("g1_nr_clr", if_a.new_record, 1'b0);

    // Game 2: lower score keeps the old record.
    press();
    check("g2_start", if_a.game_state, 2'd1);
    tick_n(40);
    collide();
    @(negedge clk);
    check("g2_end", if_a.game_state, 2'd2);
    check("g2_score", if_a.score, 16'h0005);
`ifdef HIGH_SCORE_EN
    check("g2_high", if_a.high_score, 16'h0012);
`else
    check("g2_high", if_a.high_score, 16'h0000);
`endif
    check("g2_nr", if_a.new_record, 1'b0);
    reset_cycle("g2");

    // Game 3: asynchronous rst mid-game.
    press();
    tick_n(336);
    check("g3_score42", if_a.score, 16'h0042);
    @(negedge clk) rst = 1'b1;
    #1;
    check("g3_arst_state", if_a.game_state, 2'd0);
    check("g3_arst_score", if_a.score, 16'h0000);
    check("g3_arst_high", if_a.high_score, 16'h0000);
    @(negedge clk) rst = 1'b0;

    // Game 4: saturation with SCORE_DIV=1.
    press();
    check("g4_start", if_b.game_state, 2'd1);
    tick_n(10005);
    check("g4_sat", if_b.score, 16'h9999);
    check("g4_a_score", if_a.score, 16'h1250);
    tick_n(2);
    check("g4_sat_hold", if_b.score, 16'h9999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
